exec_alu_core: RTL and testbench

EXEC_ALU_CORE -- requirements
Module: exec_alu_core

---
 rtl/exec_alu_core.sv | 155 +++++++++++++++
 tb/tb_exec_alu_core.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_alu_core.sv
// Execute-stage ALU: operand select, immediate extend, branch/jump targets.
// All results registered with one cycle of latency.
package exec_alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_ADDU = 5'd1,
    OP_SUB  = 5'd2,
    OP_SUBU = 5'd3,
    OP_AND  = 5'd4,
    OP_OR   = 5'd5,
    OP_XOR  = 5'd6,
    OP_NOR  = 5'd7,
    OP_SLT  = 5'd8,
    OP_SLTU = 5'd9,
    OP_SLL  = 5'd10,
    OP_SRL  = 5'd11,
    OP_SRA  = 5'd12,
    OP_LUI  = 5'd13
  } alu_op_e;

  typedef struct packed {
    logic [31:0] alu_out;
    logic [31:0] jpc;
    logic [31:0] bpc;
    logic        zero;
    logic        overflow;
  } ex_res_t;

endpackage

module exec_alu_core
  import exec_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        ext_op,
  input  logic        alu_src,
  input  logic        shf_src,
  input  logic [4:0]  shamt,
  input  logic [4:0]  alu_op,
  input  logic [15:0] imm,
  input  logic [31:0] pc_new,
  input  logic [31:0] bus_a,
  input  logic [31:0] bus_b,
  input  logic [25:0] target,
  output logic        out_valid,
  output logic [31:0] alu_out,
  output logic [31:0] jpc,
  output logic [31:0] bpc,
  output logic        zero,
  output logic        overflow
);

  logic [31:0] ext_imm;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] sum;
  logic [31:0] diff;
  logic        add_ovf;
  logic        sub_ovf;
  logic [31:0] result;
  logic        ovf;
  logic [31:0] br_off;

  ex_res_t res_d;
  ex_res_t res_q;
  logic    valid_d;
  logic    valid_q;

  always_comb begin
    ext_imm = ext_op ? {{16{imm[15]}}, imm}
                     : {16'b0, imm};
    op_a = shf_src ? {27'b0, shamt} : bus_a;
    op_b = alu_src ? ext_imm : bus_b;
  end

  always_comb begin
    sum  = op_a + op_b;
    diff = op_a - op_b;
    add_ovf = (op_a[31] == op_b[31]) &&
              (sum[31] != op_a[31]);
    sub_ovf = (op_a[31] != op_b[31]) &&
              (diff[31] != op_a[31]);
  end

  always_comb begin
    result = 32'b0;
    ovf    = 1'b0;
    unique case (alu_op)
      OP_ADD: begin
        result = sum;
        ovf    = add_ovf;
      end
      OP_ADDU: result = sum;
      OP_SUB: begin
        result = diff;
        ovf    = sub_ovf;
      end
      OP_SUBU: result = diff;
      OP_AND:  result = op_a & op_b;
      OP_OR:   result = op_a | op_b;
      OP_XOR:  result = op_a ^ op_b;
      OP_NOR:  result = ~(op_a | op_b);
      OP_SLT:
        result = {31'b0,
          $signed(op_a) < $signed(op_b)};
      OP_SLTU:
        result = {31'b0, op_a < op_b};
      OP_SLL:  result = op_b << op_a[4:0];
      OP_SRL:  result = op_b >> op_a[4:0];
      OP_SRA:
        result = 32'($signed(op_b) >>> op_a[4:0]);
      OP_LUI:  result = op_b << 16;
      default: begin
        result = 32'b0;
        ovf    = 1'b0;
      end
    endcase
  end

  // Branch offset is always sign-extended, independent of ext_op.
  assign br_off = {{14{imm[15]}}, imm, 2'b00};

  always_comb begin
    valid_d = in_valid;
    res_d   = res_q;
    if (in_valid) begin
      res_d.alu_out  = result;
      res_d.overflow = ovf;
      res_d.zero     = (result == 32'b0);
      res_d.jpc      = {pc_new[31:28], target, 2'b00};
      res_d.bpc      = (pc_new - 32'd4) + br_off;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
    end
  end

  assign out_valid = valid_q;
  assign alu_out   = res_q.alu_out;
  assign jpc       = res_q.jpc;
  assign bpc       = res_q.bpc;
  assign zero      = res_q.zero;
  assign overflow  = res_q.overflow;

endmodule

// File: tb/tb_exec_alu_core.sv
// Directed bench for exec_alu_core.
// Hand-computed vectors checked with immediate assertions.
module tb_exec_alu_core;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        ext_op;
  logic        alu_src;
  logic        shf_src;
  logic [4:0]  shamt;
  logic [4:0]  alu_op;
  logic [15:0] imm;
  logic [31:0] pc_new;
  logic [31:0] bus_a;
  logic [31:0] bus_b;
  logic [25:0] target;
  logic        out_valid;
  logic [31:0] alu_out;
  logic [31:0] jpc;
  logic [31:0] bpc;
  logic        zero;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  exec_alu_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .ext_op   (ext_op),
    .alu_src  (alu_src),
    .shf_src  (shf_src),
    .shamt    (shamt),
    .alu_op   (alu_op),
    .imm      (imm),
    .pc_new   (pc_new),
    .bus_a    (bus_a),
    .bus_b    (bus_b),
    .target   (target),
    .out_valid(out_valid),
    .alu_out  (alu_out),
    .jpc      (jpc),
    .bpc      (bpc),
    .zero     (zero),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic v,
                        input logic [4:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
    in_valid = v;
    alu_op   = op;
    bus_a    = a;
    bus_b    = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    ext_op   = 1'b0;
    alu_src  = 1'b0;
    shf_src  = 1'b0;
    shamt    = 5'd0;
    alu_op   = 5'd0;
    imm      = 16'h0;
    pc_new   = 32'h0;
    bus_a    = 32'h0;
    bus_b    = 32'h0;
    target   = 26'h0;

    tick();
    tick();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_alu", alu_out, 32'h0);
    chk("rst_jpc", jpc, 32'h0);
    chk("rst_bpc", bpc, 32'h0);
    chk("rst_zero", {31'b0, zero}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    rst_n = 1'b1;

    // ADD signed overflow
    set_op(1'b1, 5'd0, 32'h7FFFFFFF, 32'h1);
    tick();
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_res", alu_out, 32'h80000000);
    chk("add_ovf", {31'b0, overflow}, 32'd1);
    chk("add_zero", {31'b0, zero}, 32'd0);

    // ADDU same operands, no overflow flag
    set_op(1'b1, 5'd1, 32'h7FFFFFFF, 32'h1);
    tick();
    chk("addu_res", alu_out, 32'h80000000);
    chk("addu_ovf", {31'b0, overflow}, 32'd0);

    // SUB to zero with branch target
    set_op(1'b1, 5'd2, 32'h12345678, 32'h12345678);
    imm    = 16'hFFFF;
    pc_new = 32'h00400010;
    tick();
    chk("sub_res", alu_out, 32'h0);
    chk("sub_zero", {31'b0, zero}, 32'd1);
    chk("sub_ovf", {31'b0, overflow}, 32'd0);
    chk("sub_bpc", bpc, 32'h00400008);

    // SUB signed overflow
    set_op(1'b1, 5'd2, 32'h80000000, 32'h1);
    tick();
    chk("subo_res", alu_out, 32'h7FFFFFFF);
    chk("subo_ovf", {31'b0, overflow}, 32'd1);

    // Immediate extension
    set_op(1'b1, 5'd1, 32'h0, 32'hDEADBEEF);
    alu_src = 1'b1;
    imm     = 16'h8000;
    ext_op  = 1'b1;
    tick();
    chk("ext_sign", alu_out, 32'hFFFF8000);
    ext_op = 1'b0;
    tick();
    chk("ext_zero", alu_out, 32'h00008000);

    // LUI
    alu_op = 5'd13;
    imm    = 16'h1234;
    tick();
    chk("lui", alu_out, 32'h12340000);
    alu_src = 1'b0;

    // Shifts by shamt
    shf_src = 1'b1;
    shamt   = 5'd4;
    set_op(1'b1, 5'd10, 32'hFFFFFFFF, 32'hF0000000);
    tick();
    chk("sll", alu_out, 32'h0);
    chk("sll_zero", {31'b0, zero}, 32'd1);
    alu_op = 5'd11;
    tick();
    chk("srl", alu_out, 32'h0F000000);
    chk("srl_zero", {31'b0, zero}, 32'd0);
    alu_op = 5'd12;
    tick();
    chk("sra", alu_out, 32'hFF000000);
    shf_src = 1'b0;

    // Shift amount uses only A[4:0]
    set_op(1'b1, 5'd10, 32'hFFFFFFE1, 32'h1);
    tick();
    chk("sll_a40", alu_out, 32'h2);

    // SLT/SLTU and jump target
    set_op(1'b1, 5'd8, 32'hFFFFFFFF, 32'h1);
    pc_new = 32'hA0000004;
    target = 26'h3FFFFFF;
    tick();
    chk("slt", alu_out, 32'h1);
    chk("jpc", jpc, 32'hAFFFFFFC);
    alu_op = 5'd9;
    tick();
    chk("sltu", alu_out, 32'h0);

    // Logic ops
    set_op(1'b1, 5'd7, 32'h0, 32'h0);
    tick();
    chk("nor", alu_out, 32'hFFFFFFFF);
    set_op(1'b1, 5'd6, 32'hFF00FF00, 32'h0F0F0F0F);
    tick();
    chk("xor", alu_out, 32'hF00FF00F);
    set_op(1'b1, 5'd4, 32'hFF00FF00, 32'h0F0F0F0F);
    tick();
    chk("and", alu_out, 32'h0F000F00);

    // Unused opcode
    set_op(1'b1, 5'd20, 32'h7FFFFFFF, 32'h1);
    tick();
    chk("op20_res", alu_out, 32'h0);
    chk("op20_ovf", {31'b0, overflow}, 32'd0);
    chk("op20_zero", {31'b0, zero}, 32'd1);

    // Hold when in_valid=0
    set_op(1'b1, 5'd5, 32'h00F0, 32'h0F00);
    pc_new = 32'h10000010;
    imm    = 16'h0004;
    target = 26'h0000001;
    tick();
    chk("or", alu_out, 32'h0FF0);
    set_op(1'b0, 5'd0, 32'h1, 32'h1);
    pc_new = 32'h20000000;
    imm    = 16'h0100;
    tick();
    chk("hold_valid", {31'b0, out_valid}, 32'd0);
    chk("hold_res", alu_out, 32'h0FF0);
    chk("hold_bpc", bpc, 32'h1000001C);
    chk("hold_jpc", jpc, 32'h10000004);

    // Mid-stream asynchronous reset
    set_op(1'b1, 5'd1, 32'h5, 32'h6);
    tick();
    chk("pre_rst", alu_out, 32'hB);
    set_op(1'b1, 5'd1, 32'h7, 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_res", alu_out, 32'h0);
    chk("arst_jpc", jpc, 32'h0);
    chk("arst_bpc", bpc, 32'h0);
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    chk("post_valid", {31'b0, out_valid}, 32'd0);
    chk("post_res", alu_out, 32'h0);
    chk("post_zero", {31'b0, zero}, 32'd0);
    set_op(1'b1, 5'd1, 32'h7, 32'h8);
    tick();
    chk("first_valid", {31'b0, out_valid}, 32'd1);
    chk("first_res", alu_out, 32'hF);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
